// File: rtl/hyperram_txn_engine.sv
// hyperram_txn_engine: runs one complete 32-bit HyperBus read or write per accepted request
module hyperram_txn_engine #(
  parameter int LATENCY     = 6,
  parameter int CSHI_CYCLES = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [3:0]  req_sel_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_rdata_o,
  output logic        hb_cs_n_o,
  output logic        hb_ck_o,
  output logic        hb_rwds_o,
  output logic        hb_rwds_oe_o,
  input  logic        hb_rwds_i,
  output logic [7:0]  hb_dq_o,
  output logic        hb_dq_oe_o,
  input  logic [7:0]  hb_dq_i
);
  typedef enum logic [2:0] {IDLE, CA, LAT, DATA, CSHI} state_t;
  localparam logic [15:0] CA_LAST   = 16'd5;
  localparam logic [15:0] LAT1_LAST = 16'(2 * LATENCY - 7);
  localparam logic [15:0] LAT2_LAST = 16'(4 * LATENCY - 7);
  localparam logic [15:0] WR_LAST   = 16'd3;
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [15:0] CSHI_LAST = 16'(CSHI_CYCLES - 1);
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic        we_q, dbl, rwds_q;
  logic [3:0]  sel_q;
  logic [31:0] wdata_q, rdata_q, rdata_n;
  logic [29:0] adr_q, adr_n;
  logic [1:0]  nb;
  logic        acc, cap, rd_done, we_n, act, rsp_n;
  logic [31:0] ha;
  logic [47:0] ca;
  logic [2:0]  k;
  logic [7:0]  dq_n;
  logic        unused_adr;
  assign unused_adr = ^req_adr_i[1:0];
  // next state, per-state cycle count, read capture and next pad byte
  always_comb begin
    acc = req_valid_i & req_ready_o;
    we_n = acc ? req_we_i : we_q;
    adr_n = acc ? req_adr_i[31:2] : adr_q;
    ha = {1'b0, adr_n, 1'b0};
    ca = {~we_n, 1'b0, 1'b1, ha[31:3], 13'd0, ha[2:0]};
    cap = state == DATA && !we_q && hb_rwds_i != rwds_q;
    rd_done = cap && nb == 2'd3;
    rdata_n = rdata_q;
    if (cap) rdata_n[{nb[1], ~nb[0], 3'b000} +: 8] = hb_dq_i;
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? CA : IDLE;
      CA:      state_n = cnt == CA_LAST ? LAT : CA;
      LAT:     state_n = cnt == (dbl ? LAT2_LAST : LAT1_LAST) ? DATA : LAT;
      DATA:    state_n = (we_q ? cnt == WR_LAST : rd_done || cnt == TO_LAST) ? CSHI : DATA;
      CSHI:    state_n = cnt == CSHI_LAST ? IDLE : CSHI;
      default: state_n = IDLE;
    endcase
    cnt_n = state_n != state ? 16'd0 : cnt + 16'd1;
    k = cnt_n[2:0];
    act = state_n == CA || state_n == LAT || state_n == DATA;
    rsp_n = state == DATA && state_n == CSHI;
    dq_n = state_n == CA ? ca[{3'd5 - k, 3'b000} +: 8] :
           state_n == DATA && we_q ? wdata_q[{k[1], ~k[0], 3'b000} +: 8] : 8'd0;
  end
  // state, request latches, latency flag and read data assembly
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      sel_q <= '0;
      wdata_q <= '0;
      adr_q <= '0;
      dbl <= 1'b0;
      rwds_q <= 1'b0;
      nb <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rwds_q <= hb_rwds_i;
      if (acc) begin
        we_q <= req_we_i;
        sel_q <= req_sel_i;
        wdata_q <= req_wdata_i;
        adr_q <= req_adr_i[31:2];
      end
      if (state == CA && cnt == 16'd2) dbl <= hb_rwds_i;
      nb <= acc ? 2'd0 : nb + {1'b0, cap};
      rdata_q <= acc ? 32'd0 : rdata_n;
    end
  end
  // registered pad and response outputs, derived from the upcoming cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_err_o <= 1'b0;
      rsp_rdata_o <= '0;
      hb_cs_n_o <= 1'b1;
      hb_ck_o <= 1'b0;
      hb_rwds_o <= 1'b0;
      hb_rwds_oe_o <= 1'b0;
      hb_dq_o <= '0;
      hb_dq_oe_o <= 1'b0;
    end else begin
      req_ready_o <= state_n == IDLE;
      rsp_valid_o <= rsp_n;
      rsp_err_o <= rsp_n && !we_q && !rd_done;
      rsp_rdata_o <= rsp_n ? rdata_n : 32'd0;
      hb_cs_n_o <= !act;
      hb_ck_o <= act && state != IDLE && !hb_ck_o;
      hb_dq_o <= dq_n;
      hb_dq_oe_o <= state_n == CA || (state_n == DATA && we_q);
      hb_rwds_oe_o <= state_n == DATA && we_q;
      hb_rwds_o <= state_n == DATA && we_q && !sel_q[{k[1], ~k[0]}];
    end
  end
endmodule

// File: tb/tb_hyperram_txn_engine.sv
// tb_hyperram_txn_engine: randomized scoreboard bench with a HyperRAM device model
module tb_hyperram_txn_engine;
  localparam int LATENCY = 6, CSHI_CYCLES = 4, TIMEOUT = 64;
  logic        wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_adr_i, req_wdata_i;
  logic [3:0]  req_sel_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        hb_cs_n_o, hb_ck_o, hb_rwds_o, hb_rwds_oe_o, hb_rwds_i, hb_dq_oe_o;
  logic [7:0]  hb_dq_o, hb_dq_i;

  hyperram_txn_engine #(.LATENCY(LATENCY), .CSHI_CYCLES(CSHI_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_sel_i(req_sel_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
    .hb_cs_n_o(hb_cs_n_o), .hb_ck_o(hb_ck_o), .hb_rwds_o(hb_rwds_o), .hb_rwds_oe_o(hb_rwds_oe_o),
    .hb_rwds_i(hb_rwds_i), .hb_dq_o(hb_dq_o), .hb_dq_oe_o(hb_dq_oe_o), .hb_dq_i(hb_dq_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {bit we; bit [3:0] sel; bit [31:0] wdata; bit [47:0] ca; int lat; int dlen; bit abort;} bus_t;
  typedef struct {bit [31:0] rdata; bit err;} rsp_t;
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int compared = 0, mismatched = 0;
  int ntog, nt, p, n;
  int pos[4];
  bit [7:0] byt[4];
  bit rw, rdbl;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  // response scoreboard: pops one expectation per rsp_valid_o strobe
  rsp_t rg;
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && rsp_valid_o) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
      else begin
        rg = rsp_q.pop_front();
        chk("rsp_err", rsp_err_o, rg.err);
        chk("rsp_rdata", rsp_rdata_o, rg.rdata);
      end
    end
  end

  // bus monitor: follows each CS# low window and compares it to the expected transaction
  bus_t e;
  bit in_txn = 0;
  int idx, gap = CSHI_CYCLES, bad, idle_bad = 0;
  bit [47:0] cag;
  bit [31:0] wseq;
  bit [3:0]  rwseq;

  task automatic end_txn(input bit rst_seen);
    chk("ca_bytes", cag, e.ca);
    chk("cycle_pattern_bad", bad, 0);
    chk("reset_during_txn", rst_seen, e.abort);
    chk("cs_low_len", idx, 6 + e.lat + e.dlen);
    if (!rst_seen) chk("rsp_on_cs_rise", rsp_valid_o, 1);
    if (e.we && !rst_seen) begin
      chk("wr_dq_bytes", wseq, {e.wdata[15:8], e.wdata[7:0], e.wdata[31:24], e.wdata[23:16]});
      chk("wr_rwds_mask", rwseq, {~e.sel[1], ~e.sel[0], ~e.sel[3], ~e.sel[2]});
    end
  endtask

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      if (in_txn) end_txn(1);
      in_txn = 0;
      gap = CSHI_CYCLES;
    end else if (!hb_cs_n_o) begin
      if (!in_txn) begin
        chk("cs_high_gap", gap >= CSHI_CYCLES, 1);
        if (bus_q.size() == 0) begin
          chk("bus_unexpected", 64'd1, 64'd0);
          e = '{default: 0};
        end else e = bus_q.pop_front();
        in_txn = 1; idx = 0; bad = 0; cag = 0; wseq = 0; rwseq = 0; gap = 0;
      end
      if (idx < 6) cag = {cag[39:0], hb_dq_o};
      if (e.we && idx >= 6 + e.lat && idx < 10 + e.lat) begin
        wseq = {wseq[23:0], hb_dq_o};
        rwseq = {rwseq[2:0], hb_rwds_o};
      end
      if (hb_ck_o !== idx[0] || hb_dq_oe_o !== (idx < 6 || (e.we && idx >= 6 + e.lat)) ||
          hb_rwds_oe_o !== (e.we && idx >= 6 + e.lat) || (!e.we && hb_rwds_o)) bad++;
      idx++;
    end else begin
      if (in_txn) end_txn(0);
      in_txn = 0;
      gap++;
      if (hb_ck_o || hb_dq_oe_o || hb_rwds_oe_o) idle_bad++;
    end
  end

  // issues one request, pushes its expectations, then plays the memory side of the bus
  task automatic txn(input bit we, input bit [31:0] adr, input bit [3:0] sel, input bit [31:0] wdata,
                     input bit dbl, input bit abort);
    bus_t b;
    rsp_t r;
    bit [31:0] ha;
    int last, w;
    bit lvl;
    int off[4] = '{8, 0, 24, 16};
    if (we) ntog = 0;
    ha = (adr >> 2) << 1;
    b.we = we; b.sel = sel; b.wdata = wdata; b.abort = abort;
    b.lat = dbl ? 4 * LATENCY - 6 : 2 * LATENCY - 6;
    b.ca = 0;
    b.ca[47] = !we;
    b.ca[45] = 1'b1;
    b.ca[44:16] = ha[31:3];
    b.ca[2:0] = ha[2:0];
    b.dlen = abort ? 1 : we ? 4 : ntog == 4 ? pos[3] + 1 : TIMEOUT;
    r.rdata = 0;
    for (int j = 0; j < ntog; j++) r.rdata[off[j] +: 8] = byt[j];
    r.err = !we && ntog < 4;
    bus_q.push_back(b);
    if (!abort) rsp_q.push_back(r);
    req_valid_i = 1; req_we_i = we; req_adr_i = adr; req_sel_i = sel; req_wdata_i = wdata;
    w = 0;
    while (!req_ready_o && w < 200) begin tick; w++; end
    chk("accept_in_time", w < 200, 1);
    tick;
    req_valid_i = 0; req_adr_i = $urandom; req_wdata_i = $urandom; req_sel_i = 4'($urandom);
    last = abort ? 13 : we ? 3 : 6 + b.lat + (ntog > 0 ? pos[ntog - 1] : 0);
    lvl = 0;
    for (int c = 0; c <= last; c++) begin
      if (c == 2) hb_rwds_i = dbl;
      if (c == 3) hb_rwds_i = 0;
      if (c >= 6 + b.lat) hb_dq_i = 8'($urandom);
      for (int j = 0; j < ntog; j++)
        if (c == 6 + b.lat + pos[j]) begin
          lvl = !lvl;
          hb_rwds_i = lvl;
          hb_dq_i = byt[j];
        end
      if (abort && c == 13) wb_rst_i = 1;
      if (c < last) tick;
    end
    if (abort) begin
      tick;
      wb_rst_i = 0;
      chk("abort_outputs", {hb_cs_n_o, hb_ck_o, hb_dq_oe_o, hb_rwds_oe_o, rsp_valid_o}, 5'b10000);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_valid_i = 0; req_we_i = 0; req_adr_i = 0; req_sel_i = 0; req_wdata_i = 0;
    hb_rwds_i = 0; hb_dq_i = 0;
    wb_rst_i = 1;
    repeat (3) tick;
    chk("reset_outputs",
        {req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, hb_cs_n_o, hb_ck_o, hb_rwds_o, hb_rwds_oe_o, hb_dq_o, hb_dq_oe_o},
        {3'b000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0});
    wb_rst_i = 0;
    tick;
    chk("ready_after_reset", req_ready_o, 1);
    txn(1, 32'h0000_0010, 4'b1111, 32'hA1B2_C3D4, 0, 0);
    txn(1, 32'h0000_0124, 4'b0101, 32'h5566_7788, 1, 0);
    ntog = 4; pos = '{0, 3, 5, 9}; byt = '{8'h11, 8'h22, 8'h33, 8'h44};
    txn(0, 32'h0000_0008, 4'h0, 32'h0, 0, 0);
    ntog = 2; pos = '{2, 7, 0, 0}; byt = '{8'h11, 8'h22, 8'h00, 8'h00};
    txn(0, 32'h0000_0040, 4'h0, 32'h0, 0, 0);
    ntog = 4; pos = '{10, 20, 30, TIMEOUT - 1}; byt = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    txn(0, 32'h1234_5678, 4'h0, 32'h0, 0, 0);
    ntog = 3; pos = '{1, 2, TIMEOUT - 1, 0}; byt = '{8'h5A, 8'hA5, 8'h3C, 8'h00};
    txn(0, 32'hFFFF_FFFC, 4'h0, 32'h0, 1, 0);
    ntog = 4; pos = '{0, 1, 2, 3}; byt = '{8'h01, 8'h02, 8'h03, 8'h04};
    txn(0, 32'h8000_0004, 4'h0, 32'h0, 1, 0);
    txn(1, 32'h0000_0200, 4'b0000, 32'hCAFE_F00D, 0, 0);
    txn(1, 32'h0000_0300, 4'b1111, 32'h0BAD_BEEF, 0, 1);
    txn(1, 32'h0000_0304, 4'b0011, 32'h1357_9BDF, 0, 0);
    for (int t = 0; t < 24; t++) begin
      rw = 1'($urandom);
      rdbl = 1'($urandom);
      nt = $urandom_range(0, 4);
      ntog = 0;
      p = -1;
      for (int j = 0; j < nt; j++) begin
        p = p + 1 + $urandom_range(0, 20);
        if (p < TIMEOUT) begin
          pos[ntog] = p;
          byt[ntog] = 8'($urandom);
          ntog++;
        end
      end
      txn(rw, $urandom, 4'($urandom), $urandom, rdbl, 0);
    end
    n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0 || in_txn) && n < 500) begin tick; n++; end
    chk("drain_queues", rsp_q.size() + bus_q.size(), 0);
    repeat (6) tick;
    chk("idle_outputs", idle_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
